// File: rtl/imem_loader_if.sv
// Byte-stream and memory-write bundle for imem_loader.
// The master side drives the incoming byte stream and observes the memory write
// port (host/UART side). The slave side is the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 64
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output s_valid, s_data,
    input  s_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction memory.
// Takes a big-endian 32-bit length header followed by that many payload bytes,
// writes them to consecutive byte addresses from 0 and holds the core in reset
// until a clean load has completed.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing modulo-256
// checksum byte that is verified but never written to memory.
//
// state | meaning
// IDLE  | after reset, waiting for start
// HDR   | collecting the 4 length bytes, MSB first
// DATA  | accepting payload bytes (written, or discarded in drain mode)
// CSUM  | accepting the checksum byte (only with IMEM_LOADER_CHECKSUM_EN)
// DONE  | load finished; cpu_hold released unless err
module imem_loader #(
  parameter int MEM_SIZE = 4095,
  parameter int ADDR_W   = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_hold,
  output logic [31:0]   byte_count
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CSUM = 3'd4,
`endif
    ST_DONE = 3'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              s_ready;
  logic              accept;
  logic              load_start;
  logic              err_set;
  logic [1:0]        hdr_cnt;
  logic [31:0]       len;
  logic [31:0]       len_full;
  logic              drain;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  // The byte port is open in every state that consumes stream bytes.
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign s_ready = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
  assign busy    = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
`else
  assign s_ready = (state == ST_HDR) || (state == ST_DATA);
  assign busy    = (state == ST_HDR) || (state == ST_DATA);
`endif
  assign accept   = bus.s_valid && s_ready;
  assign done     = (state == ST_DONE);
  assign len_full = {len[23:0], bus.s_data};

  assign bus.s_ready = s_ready;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode plus the error and load-start strobes.
  always_comb begin
    state_nxt  = state;
    load_start = 1'b0;
    err_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt  = ST_HDR;
          load_start = 1'b1;
        end
      end
      ST_HDR: begin
        if (accept && (hdr_cnt == 2'd3)) begin
          if (len_full == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nxt = ST_CSUM;
`else
            state_nxt = ST_DONE;
`endif
          end else begin
            state_nxt = ST_DATA;
            if (len_full > 32'(MEM_SIZE)) err_set = 1'b1;
          end
        end
      end
      ST_DATA: begin
        // len is non-zero here, so len-1 cannot wrap.
        if (accept && (byte_count == len - 32'd1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = ST_CSUM;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) begin
          state_nxt = ST_DONE;
          if (bus.s_data != csum) err_set = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        if (start) begin
          state_nxt  = ST_HDR;
          load_start = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Length capture, byte counting, registered write port and core hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr_cnt    <= 2'd0;
      len        <= 32'd0;
      drain      <= 1'b0;
      byte_count <= 32'd0;
      err        <= 1'b0;
      cpu_hold   <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      if (load_start) begin
        hdr_cnt    <= 2'd0;
        len        <= 32'd0;
        drain      <= 1'b0;
        byte_count <= 32'd0;
        err        <= 1'b0;
        cpu_hold   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum       <= 8'd0;
`endif
      end
      if ((state == ST_HDR) && accept) begin
        len     <= len_full;
        hdr_cnt <= hdr_cnt + 2'd1;
        // An oversize length is still consumed in full so the stream stays framed.
        if (err_set) drain <= 1'b1;
      end
      if ((state == ST_DATA) && accept) begin
        if (byte_count != 32'hFFFF_FFFF) byte_count <= byte_count + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= csum + bus.s_data;
`endif
        if (!drain) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= ADDR_W'(byte_count);
          wr_data_q <= bus.s_data;
        end
      end
      if (err_set) err <= 1'b1;
      if ((state_nxt == ST_DONE) && (state != ST_DONE)) cpu_hold <= err || err_set;
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Byte-stream program loader that fills the instruction memory's byte write port before the core runs. It takes a big-endian 32-bit length header, then that many payload bytes, and writes them to consecutive byte addresses starting at 0. It holds the core in reset until loading completes. It sits between the host/UART byte source and the instruction memory.

Parameters:
MEM_SIZE, 4095, number of writable bytes in instruction memory; valid addresses are 0..MEM_SIZE-1
ADDR_W, 64, width of the write address; matches the core fetch address width

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE
s_valid  in  1  input byte valid
s_data  in  8  input byte
s_ready  out  1  loader accepts a byte; a byte transfers when s_valid && s_ready at a rising edge
wr_en  out  1  memory byte write strobe
wr_addr  out  ADDR_W  byte write address
wr_data  out  8  byte to write
busy  out  1  high in HDR or DATA state
done  out  1  high in DONE state
err  out  1  error flag; valid when done=1
cpu_hold  out  1  holds the core in reset while high
byte_count  out  32  number of payload bytes accepted in the current load

Behaviour:
- Reset (reset=0, asynchronous) forces the following values:
  - state=IDLE, s_ready=0, wr_en=0, wr_addr=0, wr_data=0
  - busy=0, done=0, err=0, cpu_hold=1, byte_count=0
- States: IDLE, HDR, DATA, DONE. With CHECKSUM_EN, a CSUM state is added.
- IDLE: s_ready=0. When start=1 -> HDR; clear the length register, byte_count and err.
- HDR: s_ready=1. Accept 4 bytes into len[31:0], MSB first (big-endian, same byte order as fetch).
  - After the 4th byte, if len==0 -> DONE.
  - Otherwise -> DATA. If len > MEM_SIZE, set err=1 and enter drain mode.
- DATA: s_ready=1. On each accepted byte, byte_count increments.
  - Normal mode: one cycle after the accept, wr_en=1, wr_addr=byte_count (pre-increment value), wr_data=accepted byte. The write path is registered, so latency is exactly 1 cycle.
  - Drain mode: accepted bytes are discarded and wr_en stays 0.
  - When byte_count reaches len -> DONE (or CSUM).
  - Back-to-back accepts produce back-to-back wr_en pulses, one per byte.
- DONE: s_ready=0, done=1.
  - cpu_hold drops to 0 in the cycle DONE is entered, but only if err=0. If err=1, cpu_hold stays 1.
  - start=1 in DONE -> HDR: cpu_hold=1, done=0, err=0, byte_count=0. This is a reload.
- start while busy=1 is ignored.
- s_valid while s_ready=0 is ignored; no byte is consumed.
- wr_en is never asserted outside the cycle following a normal-mode DATA accept.
- Reset mid-load aborts immediately. Memory contents already written are not restored, and cpu_hold returns to 1.
- byte_count saturates at 32'hFFFF_FFFF; wr_addr is byte_count zero-extended to ADDR_W.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN
- Defined:
  - After the last payload byte the FSM enters CSUM, with s_ready=1, and accepts one more byte.
  - That byte is compared to the 8-bit modulo-256 sum of all payload bytes.
  - A mismatch sets err=1. The state then goes to DONE.
  - For len==0 the expected checksum is 8'h00.
  - The checksum byte is never written to memory.
- Undefined: there is no CSUM state, and DATA goes directly to DONE.

Test Plan:
- Reset release, no start -> cpu_hold=1, s_ready=0, done=0, wr_en=0 held for 20 cycles.
- start, then bytes 00 00 00 04, 13 05 A0 00 with s_valid held high -> 4 consecutive wr_en pulses at addr 0..3 with data 13,05,A0,00, each 1 cycle after its accept; then done=1, cpu_hold=0, err=0, byte_count=4.
- Same load with s_valid toggling 1/0 every cycle -> identical writes with gaps; no duplicated or dropped bytes.
- Header 00 00 10 00 (4096 > 4095) followed by 4096 bytes -> zero wr_en pulses, byte_count=4096, done=1, err=1, cpu_hold=1.
- Header 00 00 00 00 -> DONE 1 cycle after the 4th header byte, no writes, cpu_hold=0. A start in DONE then reloads, and cpu_hold=1 again.
- reset pulsed low after 2 of 8 payload bytes -> outputs return to reset values asynchronously; a subsequent start and full load completes normally. With IMEM_LOADER_CHECKSUM_EN, payload 01 02 03 plus checksum 06 gives err=0, and checksum 07 gives err=1.
